// File: rtl/sed_pkg.sv
// Shared types and helpers for the SED scan controller: FSM state encoding,
// width calculation and next-set-bank search over a mask of up to 16 banks.
package sed_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } sed_state_t;

   localparam int SED_MAX_BANKS = 16;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } sed_next_t;

   // Never returns less than 1 so single-bank / tiny builds keep legal vectors
   function automatic int sed_clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

   function automatic sed_next_t sed_next_bank(input logic [SED_MAX_BANKS-1:0] mask,
                                                input logic [3:0]               cur);
      sed_next_t r;
      r.valid = 1'b0;
      r.idx   = 4'd0;
      for (int i = SED_MAX_BANKS - 1; i >= 0; i--) begin
         if ((i > int'(cur)) && mask[i]) begin
            r.valid = 1'b1;
            r.idx   = i[3:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sed_frame_counter.sv
// Modulo-FRAMES frame counter for the SED scan; tc flags the last frame of a bank.
module sed_frame_counter
   import sed_pkg::*;
#(
   parameter int FRAMES = 1024
) (
   input  logic clkout,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam int            CW   = sed_clog2(FRAMES);
   localparam logic [CW-1:0] LAST = CW'(FRAMES - 1);

   logic [CW-1:0] count_r;

   // Frame position within the current bank
   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc) begin
         count_r <= (count_r == LAST) ? '0 : count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = (count_r == LAST);

endmodule

// File: rtl/sed_scan_ctrl.sv
// Multi-bank SED scan controller. Define SED_FRCERR_EN to let frc_err force
// CHECK failures; otherwise frc_err is accepted but ignored.
module sed_scan_ctrl
   import sed_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int FRAMES    = 1024,
   parameter int ERRCNT_W  = 8
) (
   input  logic                             clkout,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             start,
   input  logic                             always_mode,
   input  logic [NUM_BANKS-1:0]             bank_mask,
   input  logic [NUM_BANKS-1:0]             bank_fail,
   input  logic [NUM_BANKS-1:0]             frc_err,
   input  logic                             err_clr,
   output logic                             inprog,
   output logic                             done,
   output logic                             err,
   output logic [sed_clog2(NUM_BANKS)-1:0]  err_bank,
   output logic [ERRCNT_W-1:0]              err_count,
   output logic [sed_clog2(NUM_BANKS)-1:0]  cur_bank
);

   localparam int BW = sed_clog2(NUM_BANKS);

   sed_state_t            state_r, next_s;
   logic                  start_q;
   logic [NUM_BANKS-1:0]  mask_r;
   logic                  start_cond_s;
   logic                  load_first_s;
   logic                  check_s;
   logic                  cnt_clr_s;
   logic                  cnt_inc_s;
   logic                  cnt_tc_s;
   logic                  fail_s;
   logic [BW-1:0]         first_idx_s;
   sed_next_t             first_s;
   sed_next_t             next_bank_s;

   assign start_cond_s = enable & ((start & ~start_q) | always_mode);
   assign next_bank_s  = sed_next_bank(SED_MAX_BANKS'(mask_r), 4'(cur_bank));

   // Lowest enabled bank of the mask presented at scan start
   always_comb begin
      first_s     = sed_next_bank(SED_MAX_BANKS'(bank_mask), 4'd0);
      first_idx_s = '0;
      if (bank_mask[0]) begin
         first_idx_s = '0;
      end else begin
         first_idx_s = BW'(first_s.idx);
      end
   end

`ifdef SED_FRCERR_EN
   assign fail_s = bank_fail[cur_bank] | frc_err[cur_bank];
`else
   logic unused_frc_s;
   assign unused_frc_s = ^frc_err;
   assign fail_s       = bank_fail[cur_bank];
`endif

   // State register
   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next state and per-cycle control strobes; enable low forces IDLE
   always_comb begin
      next_s       = state_r;
      cnt_clr_s    = 1'b1;
      cnt_inc_s    = 1'b0;
      load_first_s = 1'b0;
      check_s      = 1'b0;
      if (!enable) begin
         next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_cond_s) begin
                  load_first_s = 1'b1;
                  next_s       = (bank_mask == '0) ? DONE : SCAN;
               end else begin
                  next_s = IDLE;
               end
            end
            SCAN: begin
               cnt_clr_s = 1'b0;
               cnt_inc_s = 1'b1;
               if (cnt_tc_s) begin
                  next_s = CHECK;
               end else begin
                  next_s = SCAN;
               end
            end
            CHECK: begin
               check_s = 1'b1;
               if (next_bank_s.valid) begin
                  next_s = SCAN;
               end else begin
                  next_s = DONE;
               end
            end
            DONE: begin
               next_s = IDLE;
            end
            default: begin
               next_s = IDLE;
            end
         endcase
      end
   end

   sed_frame_counter #(
      .FRAMES (FRAMES)
   ) u_frame_counter (
      .clkout (clkout),
      .reset  (reset),
      .clr    (cnt_clr_s),
      .inc    (cnt_inc_s),
      .tc     (cnt_tc_s)
   );

   // Start edge detect, pass mask and current bank
   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         start_q  <= 1'b0;
         mask_r   <= '0;
         cur_bank <= '0;
      end else begin
         start_q <= start;
         if (load_first_s) begin
            mask_r   <= bank_mask;
            cur_bank <= first_idx_s;
         end else if (check_s && next_bank_s.valid) begin
            mask_r   <= mask_r;
            cur_bank <= BW'(next_bank_s.idx);
         end else begin
            mask_r   <= mask_r;
            cur_bank <= cur_bank;
         end
      end
   end

   // Sticky error capture; a fail in the same cycle as err_clr wins
   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         err       <= 1'b0;
         err_bank  <= '0;
         err_count <= '0;
      end else if (check_s && fail_s) begin
         err <= 1'b1;
         if (err_clr) begin
            err_count <= ERRCNT_W'(1);
            err_bank  <= cur_bank;
         end else begin
            err_count <= (err_count == '1) ? err_count : err_count + ERRCNT_W'(1);
            err_bank  <= err ? err_bank : cur_bank;
         end
      end else if (err_clr) begin
         err       <= 1'b0;
         err_bank  <= '0;
         err_count <= '0;
      end else begin
         err       <= err;
         err_bank  <= err_bank;
         err_count <= err_count;
      end
   end

   assign inprog = (state_r == SCAN) || (state_r == CHECK);
   assign done   = (state_r == DONE);

endmodule
